// File: rtl/aes_shift_rows_stream.sv
// aes_shift_rows_stream
// Column-serial ShiftRows / InvShiftRows engine for an NB-column Rijndael
// state. Two ping-pong block buffers let one block be written while the
// previous one is read out, so each side moves one column per cycle.
// Byte order of a column: [31:24] row 0 ... [7:0] row 3.

module aes_shift_rows_stream #(
    parameter int NB = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    input  logic        in_inv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic        out_last,
    output logic        busy
);

    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    // Rijndael row offsets: rows 2 and 3 shift further for the 256-bit block
    localparam int OFF1 = 1;
    localparam int OFF2 = (NB == 8) ? 3 : 2;
    localparam int OFF3 = (NB == 8) ? 4 : 3;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : gBadNb
            $error("aes_shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    // Stored column that feeds output column 'col' for a row with offset 'off'
    function automatic logic [CW-1:0] srcCol(input logic [CW-1:0] col,
                                             input int off,
                                             input logic inv);
        int idx;
        if (inv) idx = int'(col) - off + NB;
        else     idx = int'(col) + off;
        if (idx >= NB) idx = idx - NB;
        return CW'(idx);
    endfunction

    logic [31:0]   r_buf [2][NB];
    logic [1:0]    r_full;
    logic [1:0]    r_inv;
    logic          r_wsel;
    logic          r_rsel;
    logic [CW-1:0] r_wcnt;
    logic [CW-1:0] r_rcnt;

    logic          w_inFire;
    logic          w_outFire;
    logic          w_wrDone;
    logic          w_rdDone;
    logic [1:0]    w_fullNext;
    logic          w_rdInv;
    logic [31:0]   w_outCol;

    assign in_ready  = ~r_full[r_wsel];
    assign out_valid = r_full[r_rsel];
    assign out_last  = out_valid && (r_rcnt == LAST);
    assign out_col   = w_outCol;
    assign busy      = (|r_full) | (r_wcnt != '0);

    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;
    assign w_wrDone  = w_inFire && (r_wcnt == LAST);
    assign w_rdDone  = w_outFire && (r_rcnt == LAST);

    // Full flags: a write completion and a read completion always target
    // different buffers, so both updates can be applied in the same cycle
    always_comb begin
        w_fullNext = r_full;
        if (w_rdDone) w_fullNext[r_rsel] = 1'b0;
        if (w_wrDone) w_fullNext[r_wsel] = 1'b1;
    end

    // Column storage is not reset; the full flags alone say what is valid
    always_ff @(posedge clk) begin
        if (w_inFire) r_buf[r_wsel][r_wcnt] <= in_col;
    end

    // Write/read pointers, beat counters, full flags and per-block mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= '0;
            r_inv  <= '0;
            r_wsel <= 1'b0;
            r_rsel <= 1'b0;
            r_wcnt <= '0;
            r_rcnt <= '0;
        end else begin
            r_full <= w_fullNext;
            if (w_inFire) begin
                if (r_wcnt == '0) r_inv[r_wsel] <= in_inv;
                if (w_wrDone) begin
                    r_wcnt <= '0;
                    r_wsel <= ~r_wsel;
                end else begin
                    r_wcnt <= r_wcnt + CW'(1);
                end
            end
            if (w_outFire) begin
                if (w_rdDone) begin
                    r_rcnt <= '0;
                    r_rsel <= ~r_rsel;
                end else begin
                    r_rcnt <= r_rcnt + CW'(1);
                end
            end
        end
    end

    // Output column gathers each row byte from its shifted source column
    always_comb begin
        w_rdInv  = r_inv[r_rsel];
        w_outCol = '0;
        w_outCol[31:24] = r_buf[r_rsel][srcCol(r_rcnt, 0,    w_rdInv)][31:24];
        w_outCol[23:16] = r_buf[r_rsel][srcCol(r_rcnt, OFF1, w_rdInv)][23:16];
        w_outCol[15:8]  = r_buf[r_rsel][srcCol(r_rcnt, OFF2, w_rdInv)][15:8];
        w_outCol[7:0]   = r_buf[r_rsel][srcCol(r_rcnt, OFF3, w_rdInv)][7:0];
    end

endmodule

// File: tb/tb_aes_shift_rows_stream.sv
// tb_aes_shift_rows_stream
// Directed bench for the ShiftRows stream engine: one NB=4 and one NB=8
// instance, expected columns queued per block and popped on each output beat.

module tb_aes_shift_rows_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        inValid4, inReady4, inInv4, outValid4, outReady4, outLast4, busy4;
    logic [31:0] inCol4, outCol4;
    logic        inValid8, inReady8, inInv8, outValid8, outReady8, outLast8, busy8;
    logic [31:0] inCol8, outCol8;

    aes_shift_rows_stream #(.NB(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(inValid4), .in_ready(inReady4), .in_col(inCol4), .in_inv(inInv4),
        .out_valid(outValid4), .out_ready(outReady4), .out_col(outCol4),
        .out_last(outLast4), .busy(busy4)
    );

    aes_shift_rows_stream #(.NB(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(inValid8), .in_ready(inReady8), .in_col(inCol8), .in_inv(inInv8),
        .out_valid(outValid8), .out_ready(outReady8), .out_col(outCol8),
        .out_last(outLast8), .busy(busy8)
    );

    typedef struct packed {
        logic [31:0] col;
        logic        last;
    } expT;

    expT q4[$];
    expT q8[$];
    int  total = 0;
    int  bad = 0;
    int  cycle = 0;
    int  fireCount4 = 0;
    int  fireFirst4 = -1;
    int  fireLast4 = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] cols [8], input int n,
                                          input int c, input logic inv);
        logic [31:0] res;
        int off;
        int src;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (r == 0)      off = 0;
            else if (r == 1) off = 1;
            else if (n == 8) off = (r == 2) ? 3 : 4;
            else             off = r;
            src = inv ? (c - off + n) % n : (c + off) % n;
            res[31-8*r -: 8] = cols[src][31-8*r -: 8];
        end
        return res;
    endfunction

    // Scoreboard side: compare every accepted output beat with the queue head
    task automatic monitor();
        expT e;
        if (outValid4 && outReady4) begin
            if (fireFirst4 < 0) fireFirst4 = cycle;
            fireLast4 = cycle;
            fireCount4++;
            check1("dut4_expected_beat", q4.size() != 0, 1'b1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("dut4_col", outCol4, e.col);
                check1("dut4_last", outLast4, e.last);
            end
        end
        if (outValid8 && outReady8) begin
            check1("dut8_expected_beat", q8.size() != 0, 1'b1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("dut8_col", outCol8, e.col);
                check1("dut8_last", outLast8, e.last);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic resetStats();
        fireCount4 = 0;
        fireFirst4 = -1;
        fireLast4  = -1;
    endtask

    // Queue the block's expected columns, then drive its beats with handshake
    task automatic sendBlock(input bit wide, input logic [31:0] cols [8], input logic inv,
                             input bit toggleInv, input bit haveExp,
                             input logic [31:0] expCols [8]);
        int   n;
        int   w;
        logic beatInv;
        expT  e;
        n = wide ? 8 : 4;
        for (int c = 0; c < n; c++) begin
            e.col  = haveExp ? expCols[c] : model(cols, n, c, inv);
            e.last = (c == n - 1);
            if (wide) q8.push_back(e);
            else      q4.push_back(e);
        end
        for (int b = 0; b < n; b++) begin
            beatInv = (toggleInv && b > 0) ? ~inv : inv;
            if (wide) begin
                inValid8 = 1'b1; inCol8 = cols[b]; inInv8 = beatInv;
            end else begin
                inValid4 = 1'b1; inCol4 = cols[b]; inInv4 = beatInv;
            end
            w = 0;
            while (!(wide ? inReady8 : inReady4) && w < 200) begin
                step();
                w++;
            end
            if (w >= 200) check1("in_ready_timeout", wide ? inReady8 : inReady4, 1'b1);
            step();
        end
    endtask

    task automatic applyStimulusDrain();
        int w;
        w = 0;
        while ((q4.size() != 0 || q8.size() != 0) && w < 500) begin
            step();
            w++;
        end
        check1("drain_timeout", (q4.size() == 0) && (q8.size() == 0), 1'b1);
        repeat (3) step();
    endtask

    logic [31:0] blk [8];
    logic [31:0] exp1 [8];
    logic [31:0] blk8 [8];
    logic [31:0] exp8 [8];
    logic [31:0] rnd [8];
    logic [31:0] none [8];
    logic [31:0] holdExp;
    int          c0;
    int          tIn;

    initial begin
        reset_n  = 1'b0;
        inValid4 = 1'b0; inCol4 = '0; inInv4 = 1'b0; outReady4 = 1'b0;
        inValid8 = 1'b0; inCol8 = '0; inInv8 = 1'b0; outReady8 = 1'b0;
        for (int i = 0; i < 8; i++) none[i] = '0;
        #12;
        check1("reset_out_valid", outValid4, 1'b0);
        check1("reset_out_last", outLast4, 1'b0);
        check1("reset_busy", busy4, 1'b0);
        check1("reset_in_ready", inReady4, 1'b1);
        check1("reset_in_ready8", inReady8, 1'b1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // FIPS-197 round 1 ShiftRows, forward
        $display("[TB] scenario 1: FIPS-197 forward");
        blk  = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230, 0, 0, 0, 0};
        exp1 = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5, 0, 0, 0, 0};
        outReady4 = 1'b1;
        resetStats();
        sendBlock(1'b0, blk, 1'b0, 1'b0, 1'b1, exp1);
        inValid4 = 1'b0;
        c0 = cycle;
        check1("s1_out_valid_after_last_in", outValid4, 1'b1);
        check("s1_first_col_now", outCol4, 32'hd4bf5d30);
        applyStimulusDrain();
        check("s1_first_out_cycle", 32'(fireFirst4), 32'(c0));

        // Inverse with in_inv toggling on later beats
        $display("[TB] scenario 2: inverse, mid-block in_inv ignored");
        sendBlock(1'b0, exp1, 1'b1, 1'b1, 1'b1, blk);
        inValid4 = 1'b0;
        applyStimulusDrain();

        // NB=8 forward then inverse round trip
        $display("[TB] scenario 3: NB=8");
        outReady8 = 1'b1;
        for (int c = 0; c < 8; c++) blk8[c] = {8'(c), 8'(8 + c), 8'(16 + c), 8'(24 + c)};
        for (int c = 0; c < 8; c++) exp8[c] = model(blk8, 8, c, 1'b0);
        exp8[0] = 32'h0009131c;
        exp8[7] = 32'h0708121b;
        sendBlock(1'b1, blk8, 1'b0, 1'b0, 1'b1, exp8);
        inValid8 = 1'b0;
        applyStimulusDrain();
        sendBlock(1'b1, exp8, 1'b1, 1'b0, 1'b1, blk8);
        inValid8 = 1'b0;
        applyStimulusDrain();

        // Back-to-back streaming with alternating modes
        $display("[TB] scenario 4: streaming");
        resetStats();
        tIn = cycle;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 8; c++) rnd[c] = $urandom();
            sendBlock(1'b0, rnd, 1'(k % 2), 1'b0, 1'b0, none);
        end
        inValid4 = 1'b0;
        check("s4_input_cycles", 32'(cycle - tIn), 32'd24);
        applyStimulusDrain();
        check("s4_output_beats", 32'(fireCount4), 32'd24);
        check("s4_output_span", 32'(fireLast4 - fireFirst4 + 1), 32'd24);

        // Backpressure: hold output, fill both buffers, then release
        $display("[TB] scenario 5: backpressure");
        resetStats();
        outReady4 = 1'b0;
        for (int c = 0; c < 8; c++) rnd[c] = $urandom();
        holdExp = model(rnd, 4, 0, 1'b0);
        sendBlock(1'b0, rnd, 1'b0, 1'b0, 1'b0, none);
        check("s5_held_col_start", outCol4, holdExp);
        for (int c = 0; c < 8; c++) rnd[c] = $urandom();
        sendBlock(1'b0, rnd, 1'b1, 1'b0, 1'b0, none);
        inValid4 = 1'b0;
        check1("s5_in_ready_drops", inReady4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("s5_held_col", outCol4, holdExp);
            check1("s5_held_last", outLast4, 1'b0);
        end
        outReady4 = 1'b1;
        for (int c = 0; c < 8; c++) rnd[c] = $urandom();
        sendBlock(1'b0, rnd, 1'b0, 1'b0, 1'b0, none);
        inValid4 = 1'b0;
        applyStimulusDrain();
        check("s5_output_beats", 32'(fireCount4), 32'd12);

        // Reset with one full block pending and a partial block
        $display("[TB] scenario 6: reset mid-operation");
        outReady4 = 1'b0;
        for (int c = 0; c < 8; c++) rnd[c] = $urandom();
        sendBlock(1'b0, rnd, 1'b0, 1'b0, 1'b0, none);
        inValid4 = 1'b1; inCol4 = 32'hdeadbeef; inInv4 = 1'b0;
        step();
        inCol4 = 32'hcafef00d;
        step();
        inValid4 = 1'b0;
        check1("s6_busy_before", busy4, 1'b1);
        check1("s6_valid_before", outValid4, 1'b1);
        reset_n = 1'b0;
        #1;
        check1("s6_out_valid_reset", outValid4, 1'b0);
        check1("s6_in_ready_reset", inReady4, 1'b1);
        check1("s6_busy_reset", busy4, 1'b0);
        q4.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        resetStats();
        outReady4 = 1'b1;
        for (int c = 0; c < 8; c++) rnd[c] = $urandom();
        sendBlock(1'b0, rnd, 1'b1, 1'b0, 1'b0, none);
        inValid4 = 1'b0;
        applyStimulusDrain();
        check("s6_output_beats", 32'(fireCount4), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_shift_rows_stream.md
Name: aes_shift_rows_stream

Overview:
Streaming, parametrised ShiftRows / InvShiftRows engine for the Rijndael state.
- State width is generalised to NB columns.
- Input and output are one 32-bit column per beat, with valid/ready handshakes.
- Blocks are ping-pong buffered so sustained throughput is one column per cycle.
- Sits between SubBytes and MixColumns in the column-serial round datapath, and serves the decrypt path through a per-block inverse mode.

Parameters:
- NB, default 4: state columns per block. Legal values are 4, 6, 8; any other value is an elaboration-time error.

Ports:
- clk  input  1  single clock; all state is updated on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_col is valid this cycle.
- in_ready  output  1  engine can accept a column this cycle.
- in_col  input  32  state column: [31:24] is row 0, [23:16] row 1, [15:8] row 2, [7:0] row 3.
- in_inv  input  1  0 selects ShiftRows, 1 selects InvShiftRows; sampled on the first beat of a block only.
- out_valid  output  1  out_col is valid.
- out_ready  input  1  downstream accepts out_col.
- out_col  output  32  shifted state column, same byte order as in_col.
- out_last  output  1  high with the final column (index NB-1) of a block.
- busy  output  1  at least one buffer is holding a full or partial block.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Shift offsets per row r (row 0, 1, 2, 3):
  - NB=4 or 6: 0, 1, 2, 3.
  - NB=8: 0, 1, 3, 4.
- Forward transform: output column c, row r = stored column (c+off_r) mod NB, row r.
- Inverse transform: output column c, row r = stored column (c-off_r+NB) mod NB, row r.
- Buffer organisation: two buffers, each NB x 32 bits, plus per buffer a full flag and a latched inv bit.
- Write side:
  - Write pointer wsel, beat counter wcnt in 0..NB-1.
  - in_ready = !full[wsel], derived from registers only; no combinational path from out_ready.
  - A transfer occurs when in_valid && in_ready: store in_col at wcnt.
  - When wcnt==0, latch in_inv into inv[wsel].
  - When wcnt==NB-1: set full[wsel], wrap wcnt to 0, toggle wsel.
- Read side:
  - Read pointer rsel, column counter rcnt in 0..NB-1.
  - out_valid = full[rsel].
  - out_col is combinational from buffer[rsel] using rcnt and inv[rsel].
  - out_last = out_valid && rcnt==NB-1.
  - A transfer occurs when out_valid && out_ready: increment rcnt.
  - When rcnt==NB-1 on a transfer: clear full[rsel], wrap rcnt to 0, toggle rsel.
- Latency:
  - out_valid rises the cycle after the edge that accepted the last input column.
  - The first output column is not available before all NB columns are in, because row shifts span the whole block.
- Throughput: with in_valid and out_ready held high, blocks stream back-to-back with no bubbles, one column per cycle on each side.
- Backpressure: while out_ready is low, out_col and out_last hold stable. in_ready stays high until the other buffer also fills, then drops.
- Simultaneous events: write completion on one buffer and read completion on the other in the same cycle are both honoured. A buffer freed on cycle t is writable from cycle t+1.
- Mode isolation: in_inv changes in mid-block are ignored. Consecutive blocks may use different modes, and each block is emitted with its own latched mode.
- Reset values:
  - Full flags, wcnt, rcnt, wsel, rsel all return to 0.
  - out_valid=0, out_last=0, busy=0, in_ready=1.
  - Buffer contents are don't-care and need not be reset.
- Reset mid-operation: partial and full blocks are discarded, and no column from a pre-reset block is ever emitted afterwards.
- busy = full[0] | full[1] | (wcnt!=0).

Test Plan:
1. FIPS-197 App. B round 1, NB=4, forward: input d42711ae, e0bf98f1, b8b45de5, 1e415230 -> output d4bf5d30, e0b452ae, b84111f1, 1e2798e5, with out_last only on the 4th column and out_valid rising one cycle after the 4th input beat.
2. Inverse, NB=4: feed the scenario-1 outputs with in_inv=1 on the first beat -> original columns d42711ae..1e415230 returned. Toggling in_inv on beats 2-4 has no effect.
3. NB=8, forward: byte (r,c)=8r+c -> out col0=0009131c, col7=0708121b. Inverse of that output restores the input exactly.
4. Streaming: 6 back-to-back NB=4 blocks with alternating modes, in_valid and out_ready held high -> 24 output beats in 24 consecutive cycles, each block correct for its latched mode.
5. Backpressure: out_ready low for 10 cycles after the first output -> out_col held stable; in_ready drops after the second block fills; no data is lost or duplicated once released.
6. Reset: reset_n asserted after 2 beats of a block, with one full block pending -> out_valid=0 and in_ready=1 immediately. A fresh block afterwards is output correctly, with no stale columns.
